// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package : bru_pkg
// Brief   : Shared types for the branch resolve unit and the fetch-side
//           predictor table. Holds the 2-bit counter encodings, the
//           redirect FSM states and the per-stage prediction metadata.
// Rev     : 1.0  initial release
// ============================================================================
package bru_pkg;

  localparam int BRU_XLEN = 32;

  // 2-bit saturating counter encodings
  localparam logic [1:0] CNT_SNT = 2'd0;  // strongly not taken
  localparam logic [1:0] CNT_WNT = 2'd1;  // weakly not taken
  localparam logic [1:0] CNT_WT  = 2'd2;  // weakly taken
  localparam logic [1:0] CNT_ST  = 2'd3;  // strongly taken

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } bru_state_e;

  // Prediction metadata carried alongside each instruction
  typedef struct packed {
    logic                valid;
    logic [BRU_XLEN-1:0] pc;
    logic [BRU_XLEN-1:0] pred_pc;
  } bru_meta_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : branch_resolve_unit_if
// Brief     : Fetch/EX-side signal bundle of the branch resolve unit.
//             slave  = the resolve unit, master = the surrounding pipeline.
// Rev       : 1.0  initial release
// ============================================================================
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) ();

  // IF / ID side
  logic             if_valid;
  logic [XLEN-1:0]  if_pc;
  logic [XLEN-1:0]  if_pred_pc;
  logic             id_stall;

  // EX resolution
  logic             ex_is_jb;
  logic             ex_taken;
  logic [XLEN-1:0]  ex_target;
  logic [1:0]       ex_counter;

  // Redirect / squash
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_ifid;
  logic             flush_idex;
  logic             ex_kill;

  // Predictor table update
  logic             upd_en;
  logic [XLEN-1:0]  upd_pc;
  logic [XLEN-1:0]  upd_target;
  logic [1:0]       upd_counter;

  // Performance counters
  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_mispredicts;

  modport slave (
    input  if_valid, if_pc, if_pred_pc, id_stall,
    input  ex_is_jb, ex_taken, ex_target, ex_counter,
    output redirect, redirect_pc, flush_ifid, flush_idex, ex_kill,
    output upd_en, upd_pc, upd_target, upd_counter,
    output perf_branches, perf_mispredicts
  );

  modport master (
    output if_valid, if_pc, if_pred_pc, id_stall,
    output ex_is_jb, ex_taken, ex_target, ex_counter,
    input  redirect, redirect_pc, flush_ifid, flush_idex, ex_kill,
    input  upd_en, upd_pc, upd_target, upd_counter,
    input  perf_branches, perf_mispredicts
  );

endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module : sat_counter2
// Brief  : Combinational 2-bit saturating increment/decrement. Shared by
//          the resolve unit and the fetch-side predictor table.
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter2
  import bru_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  // Step toward taken/not-taken, holding at the ends of the range
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module : branch_resolve_unit
// Brief  : Carries predicted next-PC through IF/ID and ID/EX, checks it in
//          EX, issues a one-cycle registered redirect + squash on mispredict
//          and produces the predictor table update one cycle after resolve.
//          Optional macro BRU_PERF_CNT_EN adds branch/mispredict counters.
// Rev    : 1.0  initial release
// ============================================================================
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN  = BRU_XLEN,  // must match BRU_XLEN (metadata struct width)
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_unit_if.slave  bus
);

  bru_meta_t        ifid_q, ifid_d;
  bru_meta_t        idex_q, idex_d;
  bru_state_e       state_q;

  logic             redirect_q;
  logic             flush_ifid_q;
  logic             flush_idex_q;
  logic             ex_kill_q;
  logic [XLEN-1:0]  redirect_pc_q;

  logic             upd_en_q;
  logic [XLEN-1:0]  upd_pc_q;
  logic [XLEN-1:0]  upd_target_q;
  logic [1:0]       upd_counter_q;

  logic             ex_live;
  logic             ex_upd;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  actual_pc;
  logic             mispredict;
  logic [1:0]       cnt_next;

  // Resolution: a killed EX slot never resolves anything
  assign ex_live    = idex_q.valid & ~ex_kill_q;
  assign ex_upd     = ex_live & bus.ex_is_jb;
  assign pc_plus4   = idex_q.pc + XLEN'(4);
  assign actual_pc  = (bus.ex_is_jb & bus.ex_taken) ? bus.ex_target : pc_plus4;
  // Also catches non-jb instructions that hit a stale table entry
  assign mispredict = ex_live & (actual_pc != idex_q.pred_pc);

  sat_counter2 u_sat_counter2 (
    .cnt_i   (bus.ex_counter),
    .taken_i (bus.ex_taken),
    .cnt_o   (cnt_next)
  );

  // Next metadata: flush clears both stages and takes priority over a stall
  always_comb begin
    ifid_d = ifid_q;
    idex_d = idex_q;
    if (flush_ifid_q) begin
      ifid_d.valid = 1'b0;
      idex_d.valid = 1'b0;
    end else if (bus.id_stall) begin
      idex_d.valid = 1'b0;
    end else begin
      ifid_d.valid   = bus.if_valid;
      ifid_d.pc      = bus.if_pc;
      ifid_d.pred_pc = bus.if_pred_pc;
      idex_d         = ifid_q;
    end
  end

  // IF/ID and ID/EX metadata registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q <= '0;
      idex_q <= '0;
    end else begin
      ifid_q <= ifid_d;
      idex_q <= idex_d;
    end
  end

  // Redirect FSM; squash flags are registered and live only in REDIRECT
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      redirect_q    <= 1'b0;
      flush_ifid_q  <= 1'b0;
      flush_idex_q  <= 1'b0;
      ex_kill_q     <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q   <= 1'b0;
      flush_ifid_q <= 1'b0;
      flush_idex_q <= 1'b0;
      ex_kill_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mispredict) begin
            state_q       <= ST_REDIRECT;
            redirect_q    <= 1'b1;
            flush_ifid_q  <= 1'b1;
            flush_idex_q  <= 1'b1;
            ex_kill_q     <= 1'b1;
            redirect_pc_q <= actual_pc;
          end
        end
        ST_REDIRECT: state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  // Table update, written one cycle after every correct-path jump/branch
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_en_q      <= 1'b0;
      upd_pc_q      <= '0;
      upd_target_q  <= '0;
      upd_counter_q <= CNT_SNT;
    end else begin
      upd_en_q <= ex_upd;
      if (ex_upd) begin
        upd_pc_q      <= idex_q.pc;
        upd_target_q  <= bus.ex_target;
        upd_counter_q <= cnt_next;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] perf_br_q;
  logic [CNT_W-1:0] perf_mp_q;

  // Free-running event counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (ex_upd)                           perf_br_q <= perf_br_q + CNT_W'(1);
      if (mispredict && state_q == ST_IDLE) perf_mp_q <= perf_mp_q + CNT_W'(1);
    end
  end

  assign bus.perf_branches    = perf_br_q;
  assign bus.perf_mispredicts = perf_mp_q;
`else
  assign bus.perf_branches    = {CNT_W{1'b0}};
  assign bus.perf_mispredicts = {CNT_W{1'b0}};
`endif

  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.flush_ifid  = flush_ifid_q;
  assign bus.flush_idex  = flush_idex_q;
  assign bus.ex_kill     = ex_kill_q;
  assign bus.upd_en      = upd_en_q;
  assign bus.upd_pc      = upd_pc_q;
  assign bus.upd_target  = upd_target_q;
  assign bus.upd_counter = upd_counter_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_resolve_unit
// Brief  : Directed self-checking bench for branch_resolve_unit.
// Rev    : 1.0  initial release
// ============================================================================
module tb_branch_resolve_unit;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

  branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Push one instruction through IF/ID into ID/EX
  task automatic inject(input logic [31:0] pc, input logic [31:0] pred);
    bus.if_valid   = 1'b1;
    bus.if_pc      = pc;
    bus.if_pred_pc = pred;
    tick();
    bus.if_valid   = 1'b0;
    tick();
  endtask

  // Drive EX outcome for one cycle, then return EX inputs to idle
  task automatic resolve(input logic jb, input logic tk, input logic [31:0] tgt, input logic [1:0] cnt);
    bus.ex_is_jb   = jb;
    bus.ex_taken   = tk;
    bus.ex_target  = tgt;
    bus.ex_counter = cnt;
    tick();
    bus.ex_is_jb   = 1'b0;
    bus.ex_taken   = 1'b0;
    bus.ex_target  = '0;
    bus.ex_counter = 2'd0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.if_valid   = 1'b0;
    bus.if_pc      = '0;
    bus.if_pred_pc = '0;
    bus.id_stall   = 1'b0;
    bus.ex_is_jb   = 1'b0;
    bus.ex_taken   = 1'b0;
    bus.ex_target  = '0;
    bus.ex_counter = 2'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_redirect",    bus.redirect, 0);
    check("rst_redirect_pc", bus.redirect_pc, 0);
    check("rst_flush_ifid",  bus.flush_ifid, 0);
    check("rst_ex_kill",     bus.ex_kill, 0);
    check("rst_upd_en",      bus.upd_en, 0);
    check("rst_upd_counter", bus.upd_counter, 0);
    check("rst_perf_br",     bus.perf_branches, 0);
    check("rst_perf_mp",     bus.perf_mispredicts, 0);

    // Taken branch predicted fall-through
    inject(32'h100, 32'h104);
    resolve(1'b1, 1'b1, 32'h200, 2'd1);
    check("A_redirect",    bus.redirect, 1);
    check("A_redirect_pc", bus.redirect_pc, 32'h200);
    check("A_flush_ifid",  bus.flush_ifid, 1);
    check("A_flush_idex",  bus.flush_idex, 1);
    check("A_ex_kill",     bus.ex_kill, 1);
    check("A_upd_en",      bus.upd_en, 1);
    check("A_upd_pc",      bus.upd_pc, 32'h100);
    check("A_upd_target",  bus.upd_target, 32'h200);
    check("A_upd_counter", bus.upd_counter, 2);
    tick();
    check("A_redirect_done", bus.redirect, 0);
    check("A_ex_kill_done",  bus.ex_kill, 0);

    // Correctly predicted taken, counter saturates high
    inject(32'h100, 32'h200);
    resolve(1'b1, 1'b1, 32'h200, 2'd3);
    check("B_redirect",    bus.redirect, 0);
    check("B_upd_en",      bus.upd_en, 1);
    check("B_upd_counter", bus.upd_counter, 3);

    // Correctly predicted not-taken, counter saturates low
    inject(32'h300, 32'h304);
    resolve(1'b1, 1'b0, 32'h400, 2'd0);
    check("C_redirect",    bus.redirect, 0);
    check("C_upd_en",      bus.upd_en, 1);
    check("C_upd_counter", bus.upd_counter, 0);

    // Not-taken from weakly taken decrements
    inject(32'h500, 32'h504);
    resolve(1'b1, 1'b0, 32'h600, 2'd2);
    check("D_redirect",    bus.redirect, 0);
    check("D_upd_counter", bus.upd_counter, 1);
    check("D_upd_target",  bus.upd_target, 32'h600);

    // Non-jb with a stale table hit: redirect, no table write
    inject(32'h40, 32'h80);
    resolve(1'b0, 1'b0, 32'h0, 2'd0);
    check("N_redirect",    bus.redirect, 1);
    check("N_redirect_pc", bus.redirect_pc, 32'h44);
    check("N_upd_en",      bus.upd_en, 0);
    tick();

    // Back-to-back mispredicts: second one sits in a killed slot
    bus.if_valid = 1'b1; bus.if_pc = 32'h600; bus.if_pred_pc = 32'h700;
    tick();
    bus.if_pc = 32'h604; bus.if_pred_pc = 32'h900;
    tick();
    bus.if_pc = 32'h608; bus.if_pred_pc = 32'hA00;
    resolve(1'b1, 1'b0, 32'h700, 2'd2);
    bus.if_valid = 1'b0;
    check("BB_redirect",    bus.redirect, 1);
    check("BB_redirect_pc", bus.redirect_pc, 32'h604);
    check("BB_upd_counter", bus.upd_counter, 1);
    resolve(1'b0, 1'b0, 32'h0, 2'd0);
    check("BB_second_redirect", bus.redirect, 0);
    check("BB_second_upd_en",   bus.upd_en, 0);
    tick();
    check("BB_no_leak", bus.redirect, 0);

    // Fall-through PC wraps to zero
    inject(32'hFFFF_FFFC, 32'h1000);
    resolve(1'b1, 1'b0, 32'h80, 2'd1);
    check("W_redirect",    bus.redirect, 1);
    check("W_redirect_pc", bus.redirect_pc, 32'h0);
    check("W_upd_pc",      bus.upd_pc, 32'hFFFF_FFFC);
    check("W_upd_counter", bus.upd_counter, 0);
    tick();

    // Load-use stall in the mispredict cycle: flush must still clear IF/ID
    bus.if_valid = 1'b1; bus.if_pc = 32'h700; bus.if_pred_pc = 32'h800;
    tick();
    bus.if_pc = 32'h704; bus.if_pred_pc = 32'h900;
    tick();
    bus.if_valid = 1'b0;
    bus.id_stall = 1'b1;
    resolve(1'b1, 1'b1, 32'h710, 2'd1);
    check("S_redirect",    bus.redirect, 1);
    check("S_redirect_pc", bus.redirect_pc, 32'h710);
    check("S_upd_counter", bus.upd_counter, 2);
    tick();
    bus.id_stall = 1'b0;
    check("S_redirect_done", bus.redirect, 0);
    tick();
    tick();
    check("S_flush_beats_stall", bus.redirect, 0);

`ifdef BRU_PERF_CNT_EN
    check("P_branches",    bus.perf_branches, 7);
    check("P_mispredicts", bus.perf_mispredicts, 5);
`endif

    // Reset in the middle of REDIRECT
    inject(32'h800, 32'h804);
    resolve(1'b1, 1'b1, 32'h900, 2'd1);
    check("R_redirect_before", bus.redirect, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("R_redirect",    bus.redirect, 0);
    check("R_redirect_pc", bus.redirect_pc, 0);
    check("R_flush_idex",  bus.flush_idex, 0);
    check("R_ex_kill",     bus.ex_kill, 0);
    check("R_upd_en",      bus.upd_en, 0);
    check("R_upd_counter", bus.upd_counter, 0);
    check("R_perf_br",     bus.perf_branches, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
